// File: rtl/quad_decoder_multi.sv
// quad_decoder_multi: NCH-channel quadrature decoder with input sync, glitch filter,
// signed position counter, detent grouping and sticky error. Define QUAD_SATURATE_EN to clamp position.
module quad_decoder_multi #(
  parameter int NCH      = 2,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int DETENT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       a,
  input  logic [NCH-1:0]       b,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       step_valid,
  output logic [NCH-1:0]       step_dir,
  output logic [NCH-1:0]       detent_valid,
  output logic [NCH-1:0]       detent_dir,
  output logic [NCH*CNT_W-1:0] position,
  output logic [NCH-1:0]       err
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int AW = $clog2(DETENT + 1) + 1;
  localparam logic [CW-1:0]           CNT_MAX = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0]           CNT_ONE = CW'(1);
  localparam logic signed [AW-1:0]    ACC_HI  = AW'(DETENT);
  localparam logic signed [AW-1:0]    ACC_LO  = AW'(-DETENT);
  localparam logic signed [AW-1:0]    ACC_ONE = AW'(1);
  localparam logic signed [CNT_W-1:0] POS_ONE = CNT_W'(1);
`ifdef QUAD_SATURATE_EN
  localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
`endif

  // Position of an AB code along the forward cycle 00->10->11->01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    unique case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync1 [NCH];
  (* ASYNC_REG = "TRUE" *) logic [1:0] sync2 [NCH];
  logic [CW-1:0]           stable_cnt [NCH];
  logic [1:0]              acc_ab     [NCH];
  logic [1:0]              old_ab     [NCH];
  logic [1:0]              new_ab     [NCH];
  logic signed [CNT_W-1:0] pos        [NCH];
  logic signed [AW-1:0]    accum      [NCH];
  logic [NCH-1:0]          primed;
  logic [NCH-1:0]          fire;

  logic [1:0]              delta   [NCH];
  logic signed [CNT_W-1:0] pos_nxt [NCH];
  logic signed [AW-1:0]    acc_nxt [NCH];
  logic [NCH-1:0]          accept, fwd, rev, illegal, det_hit, det_up;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      // An unprimed channel accepts its first stable level even if it equals the reset value.
      accept[i]  = (stable_cnt[i] == CNT_MAX) && (!primed[i] || (sync2[i] != acc_ab[i]));
      delta[i]   = phase(new_ab[i]) - phase(old_ab[i]);
      fwd[i]     = fire[i] && (delta[i] == 2'd1);
      rev[i]     = fire[i] && (delta[i] == 2'd3);
      illegal[i] = fire[i] && (delta[i] == 2'd2);
      pos_nxt[i] = pos[i];
      acc_nxt[i] = accum[i];
      det_hit[i] = 1'b0;
      det_up[i]  = 1'b0;
      if (fwd[i]) begin
`ifdef QUAD_SATURATE_EN
        if (pos[i] != POS_MAX) pos_nxt[i] = pos[i] + POS_ONE;
`else
        pos_nxt[i] = pos[i] + POS_ONE;
`endif
        acc_nxt[i] = accum[i] + ACC_ONE;
      end else if (rev[i]) begin
`ifdef QUAD_SATURATE_EN
        if (pos[i] != POS_MIN) pos_nxt[i] = pos[i] - POS_ONE;
`else
        pos_nxt[i] = pos[i] - POS_ONE;
`endif
        acc_nxt[i] = accum[i] - ACC_ONE;
      end
      if (acc_nxt[i] == ACC_HI) begin
        det_hit[i] = 1'b1;
        det_up[i]  = 1'b1;
        acc_nxt[i] = '0;
      end else if (acc_nxt[i] == ACC_LO) begin
        det_hit[i] = 1'b1;
        acc_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        sync1[i]      <= '0;
        sync2[i]      <= '0;
        stable_cnt[i] <= '0;
        acc_ab[i]     <= '0;
        old_ab[i]     <= '0;
        new_ab[i]     <= '0;
        pos[i]        <= '0;
        accum[i]      <= '0;
      end
      primed       <= '0;
      fire         <= '0;
      step_valid   <= '0;
      step_dir     <= '0;
      detent_valid <= '0;
      detent_dir   <= '0;
      err          <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        sync1[i] <= {a[i], b[i]};
        sync2[i] <= sync1[i];
        if (sync1[i] != sync2[i])
          stable_cnt[i] <= '0;
        else if (stable_cnt[i] != CNT_MAX)
          stable_cnt[i] <= stable_cnt[i] + CNT_ONE;
        fire[i] <= accept[i] && primed[i];
        if (accept[i]) begin
          acc_ab[i] <= sync2[i];
          old_ab[i] <= acc_ab[i];
          new_ab[i] <= sync2[i];
          primed[i] <= 1'b1;
        end
        step_valid[i]   <= fwd[i] | rev[i];
        step_dir[i]     <= fwd[i];
        detent_valid[i] <= det_hit[i];
        detent_dir[i]   <= det_up[i];
        pos[i]          <= clr[i] ? '0 : pos_nxt[i];
        accum[i]        <= clr[i] ? '0 : acc_nxt[i];
        err[i]          <= clr[i] ? 1'b0 : (err[i] | illegal[i]);
      end
    end
  end

  always_comb begin
    position = '0;
    for (int unsigned i = 0; i < NCH; i++)
      position[i*CNT_W +: CNT_W] = pos[i];
  end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// tb_quad_decoder_multi: directed and randomized stimulus checked every cycle against a
// history-based behavioural model of the decoder.
module tb_quad_decoder_multi;
  localparam int NCH      = 2;
  localparam int CNT_W    = 10;
  localparam int FILT_LEN = 4;
  localparam int DETENT   = 4;
  localparam int LAT      = FILT_LEN + 3;
  localparam int HL       = FILT_LEN + 2;
  localparam int SENT     = 99;
  localparam int PMAX     = (1 << (CNT_W - 1)) - 1;
  localparam int PMIN     = -(1 << (CNT_W - 1));

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH-1:0]       a = '0;
  logic [NCH-1:0]       b = '0;
  logic [NCH-1:0]       clr = '0;
  logic [NCH-1:0]       step_valid, step_dir, detent_valid, detent_dir, err;
  logic [NCH*CNT_W-1:0] position;

  always #5 clk = ~clk;

  quad_decoder_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .DETENT(DETENT)
  ) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .clr(clr),
    .step_valid(step_valid), .step_dir(step_dir),
    .detent_valid(detent_valid), .detent_dir(detent_dir),
    .position(position), .err(err)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic cmp(input string name, input int c, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, c, $time, act, exp);
    end
  endtask

  function automatic int posof(input int c);
    logic signed [CNT_W-1:0] p;
    p = position[c*CNT_W +: CNT_W];
    return int'(p);
  endfunction

  // Model: raw AB history per channel; a level is accepted once the synchronised copy
  // (raw two edges back) has held for FILT_LEN edges; outputs follow one edge later.
  int  hist [NCH][HL];
  int  ord [4] = '{0, 3, 1, 2};
  int  m_acc [NCH], m_old [NCH], m_new [NCH], m_pos [NCH], m_accum [NCH];
  bit  m_valid [NCH], m_pend [NCH], m_err [NCH];
  bit  e_sv [NCH], e_sd [NCH], e_dv [NCH], e_dd [NCH];
  bit  live = 1'b0;

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int d, s2;
      bit ok;
      e_sv[c] = 0; e_sd[c] = 0; e_dv[c] = 0; e_dd[c] = 0;
      if (reset) begin
        for (int j = 0; j < HL; j++) hist[c][j] = SENT;
        hist[c][HL-1] = 0;
        hist[c][HL-2] = 0;
        m_valid[c] = 0; m_pend[c] = 0; m_acc[c] = 0;
        m_pos[c] = 0; m_accum[c] = 0; m_err[c] = 0;
      end else begin
        if (m_pend[c]) begin
          d = (ord[m_new[c]] - ord[m_old[c]] + 4) % 4;
          if (d == 2) m_err[c] = 1;
          else begin
            e_sv[c] = 1;
            e_sd[c] = (d == 1);
            m_pos[c] += (d == 1) ? 1 : -1;
`ifdef QUAD_SATURATE_EN
            if (m_pos[c] > PMAX) m_pos[c] = PMAX;
            if (m_pos[c] < PMIN) m_pos[c] = PMIN;
`else
            if (m_pos[c] > PMAX) m_pos[c] -= (1 << CNT_W);
            if (m_pos[c] < PMIN) m_pos[c] += (1 << CNT_W);
`endif
            m_accum[c] += (d == 1) ? 1 : -1;
            if (m_accum[c] == DETENT) begin
              e_dv[c] = 1; e_dd[c] = 1; m_accum[c] = 0;
            end else if (m_accum[c] == -DETENT) begin
              e_dv[c] = 1; e_dd[c] = 0; m_accum[c] = 0;
            end
          end
        end
        if (clr[c]) begin
          m_pos[c] = 0; m_accum[c] = 0; m_err[c] = 0;
        end
        s2 = hist[c][HL-2];
        ok = (s2 != SENT);
        for (int j = 0; j < FILT_LEN; j++)
          if (hist[c][HL-2-j] != s2) ok = 0;
        if (m_valid[c] && s2 == m_acc[c]) ok = 0;
        m_pend[c] = ok && m_valid[c];
        if (ok) begin
          m_old[c] = m_acc[c]; m_new[c] = s2; m_acc[c] = s2; m_valid[c] = 1;
        end
        for (int j = 0; j < HL - 1; j++) hist[c][j] = hist[c][j+1];
        hist[c][HL-1] = int'({a[c], b[c]});
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
    live = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      for (int c = 0; c < NCH; c++) begin
        cmp("step_valid", c, int'(step_valid[c]), int'(e_sv[c]));
        if (e_sv[c]) cmp("step_dir", c, int'(step_dir[c]), int'(e_sd[c]));
        cmp("detent_valid", c, int'(detent_valid[c]), int'(e_dv[c]));
        if (e_dv[c]) cmp("detent_dir", c, int'(detent_dir[c]), int'(e_dd[c]));
        cmp("position", c, posof(c), m_pos[c]);
        cmp("err", c, int'(err[c]), int'(m_err[c]));
      end
    end
  end

  logic [1:0] cur [NCH] = '{2'b00, 2'b00};

  task automatic set_ab(input int c, input logic [1:0] v);
    a[c]   = v[1];
    b[c]   = v[0];
    cur[c] = v;
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] v, input bit fw);
    case (v)
      2'b00:   nxt = fw ? 2'b10 : 2'b01;
      2'b10:   nxt = fw ? 2'b11 : 2'b00;
      2'b11:   nxt = fw ? 2'b01 : 2'b10;
      default: nxt = fw ? 2'b00 : 2'b11;
    endcase
  endfunction

  initial begin
    #1_000_000;
    nmis++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $fatal(1, "watchdog");
  end

  initial begin
    int nsv, ndv, lat, hold [NCH], r;

    // 1: reset and priming on a steady 00
    repeat (3) @(negedge clk);
    reset = 1'b0;
    nsv = 0;
    repeat (10) begin
      @(negedge clk);
      if (step_valid != '0) nsv++;
    end
    cmp("prime_no_step", 0, nsv, 0);
    cmp("prime_position", 0, posof(0), 0);
    cmp("prime_err", 0, int'(err[0]), 0);

    // 2: four forward quarter-steps on ch0
    nsv = 0; ndv = 0;
    for (int s = 0; s < 4; s++) begin
      set_ab(0, nxt(cur[0], 1'b1));
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (step_valid[0]) begin
          nsv++;
          if (lat < 0) lat = k;
        end
        if (detent_valid[0]) ndv++;
      end
      cmp("step_latency", 0, lat, LAT);
    end
    cmp("fwd_step_count", 0, nsv, 4);
    cmp("fwd_detent_count", 0, ndv, 1);
    cmp("fwd_position", 0, posof(0), 4);

    // 3: 2-cycle glitch on ch1
    set_ab(1, 2'b10);
    repeat (2) @(negedge clk);
    set_ab(1, 2'b00);
    nsv = 0;
    repeat (12) begin
      @(negedge clk);
      if (step_valid[1]) nsv++;
    end
    cmp("glitch_no_step", 1, nsv, 0);
    cmp("glitch_position", 1, posof(1), 0);

    // 4: illegal jump on ch0, then clear
    set_ab(0, 2'b11);
    nsv = 0;
    repeat (10) begin
      @(negedge clk);
      if (step_valid[0]) nsv++;
    end
    cmp("jump_no_step", 0, nsv, 0);
    cmp("jump_err", 0, int'(err[0]), 1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    cmp("clr_err", 0, int'(err[0]), 0);
    cmp("clr_position", 0, posof(0), 0);

    // 5: walk ch0 to the positive limit, then one more step
    for (int s = 0; s < PMAX; s++) begin
      set_ab(0, nxt(cur[0], 1'b1));
      repeat (5) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    cmp("at_max", 0, posof(0), PMAX);
    set_ab(0, nxt(cur[0], 1'b1));
    nsv = 0;
    repeat (10) begin
      @(negedge clk);
      if (step_valid[0]) nsv++;
    end
    cmp("limit_step_pulse", 0, nsv, 1);
`ifdef QUAD_SATURATE_EN
    cmp("past_max", 0, posof(0), PMAX);
`else
    cmp("past_max", 0, posof(0), PMIN);
`endif

    // 6: clr[1] coinciding with a ch1 step while ch0 steps in reverse
    for (int s = 0; s < 3; s++) begin
      set_ab(1, nxt(cur[1], 1'b1));
      repeat (8) @(negedge clk);
    end
    cmp("ch1_pre", 1, posof(1), 3);
    set_ab(1, nxt(cur[1], 1'b1));
    set_ab(0, nxt(cur[0], 1'b0));
    repeat (LAT - 1) @(negedge clk);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    cmp("clr_step_valid", 1, int'(step_valid[1]), 1);
    cmp("clr_step_position", 1, posof(1), 0);
    cmp("ch0_concurrent_step", 0, int'(step_valid[0]), 1);
`ifdef QUAD_SATURATE_EN
    cmp("ch0_concurrent_pos", 0, posof(0), PMAX - 1);
`else
    cmp("ch0_concurrent_pos", 0, posof(0), PMAX);
`endif

    // 7: randomized traffic with occasional clr, illegal jumps and resets
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      reset = (t == 1500) || (t == 1501) || ($urandom_range(0, 999) == 0);
      for (int c = 0; c < NCH; c++) begin
        clr[c] = ($urandom_range(0, 79) == 0);
        if (hold[c] == 0) begin
          r = $urandom_range(0, 9);
          if (r < 8) set_ab(c, nxt(cur[c], r[0]));
          else       set_ab(c, ~cur[c]);
          hold[c] = $urandom_range(1, 8);
        end else begin
          hold[c]--;
        end
      end
      @(negedge clk);
    end
    reset = 1'b0;
    clr   = '0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
